// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single register-file write port and shares it between the
//   fixed-latency ALU writeback (never back-pressured) and the
//   variable-latency load/store unit (valid/ready handshake). It also keeps
//   a scoreboard of registers that still wait for an LSU result, and it
//   stalls ID on read-after-write and write-after-write hazards against
//   those registers.
//
// Optional feature (macro STARVE_GUARD_EN):
//   When defined, a small FSM counts consecutive cycles in which the LSU is
//   blocked by the ALU. After MAX_WAIT such cycles it spends one FORCE cycle.
//   In that cycle the whole pipeline is frozen and the LSU owns the port.
//   When undefined, the ALU always wins and pipe_freeze is tied low.
//
// Parameters:
//   N         data width
//   ADDR_W    register address width (r0 is hardwired to zero)
//   MAX_WAIT  blocked LSU cycles tolerated before FORCE (guard build only)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alu_we/alu_addr/alu_data    ALU writeback request
//   lsu_valid/lsu_addr/lsu_data LSU write request, lsu_ready = accepted
//   issue_lsu/issue_addr        ID issues a long-latency op to issue_addr
//   rs_ID, rt_ID                ID source registers
//   hazard_stall                ID must hold this cycle
//   pipe_freeze                 freeze IF..WB this cycle
//   regfile_write_en/write_addr/write_data   shared write port
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int N        = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [N-1:0]      alu_data,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [N-1:0]      lsu_data,
    output logic              lsu_ready,
    input  logic              issue_lsu,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rs_ID,
    input  logic [ADDR_W-1:0] rt_ID,
    output logic              hazard_stall,
    output logic              pipe_freeze,
    output logic              regfile_write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [N-1:0]      write_data
);

    localparam int NREG = 2 ** ADDR_W;

    logic            alu_act;
    logic            alu_win;
    logic            ready_c;
    logic            handshake;
    logic            force_now;
    logic            rs_haz;
    logic            rt_haz;
    logic            waw_haz;
    logic            stall_c;
    logic            set_ok;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             blocked;

    assign force_now    = (state_q == FORCE);
    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);
    assign blocked      = lsu_valid && !ready_c;

    // Starvation FSM. wait_cnt holds the number of consecutive blocked
    // cycles seen so far. We move to FORCE on the blocked cycle that brings
    // the count to MAX_WAIT, so the LSU gets the port in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blocked) begin
                        wait_cnt_q <= CNT_W'(1);
                        state_q    <= (MAX_CNT == CNT_W'(1)) ? FORCE : WAIT;
                    end
                end
                WAIT: begin
                    if (blocked) begin
                        wait_cnt_q <= wait_cnt_inc;
                        if (wait_cnt_inc == MAX_CNT) begin
                            state_q <= FORCE;
                        end
                    end else begin
                        wait_cnt_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                FORCE: begin
                    wait_cnt_q <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    wait_cnt_q <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end
`else
    assign force_now = 1'b0;
`endif

    // Grant: the ALU cannot be back-pressured, so it wins unless FORCE is
    // active. A write to r0 is not a real write and so it never blocks the LSU.
    assign alu_act   = alu_we && (alu_addr != '0);
    assign alu_win   = alu_act && !force_now;
    assign ready_c   = lsu_valid && !alu_win;
    assign handshake = ready_c;

    // A source register that retires from the LSU in this same cycle is
    // supplied by WB forwarding, so that case does not stall. Bit 0 of the
    // scoreboard is always clear, so r0 never stalls.
    assign rs_haz  = pending_q[rs_ID] && !(handshake && (lsu_addr == rs_ID));
    assign rt_haz  = pending_q[rt_ID] && !(handshake && (lsu_addr == rt_ID));
    assign waw_haz = issue_lsu && pending_q[issue_addr];
    assign stall_c = force_now || rs_haz || rt_haz || waw_haz;
    assign set_ok  = issue_lsu && !stall_c && (issue_addr != '0);

    // Scoreboard next state. The set is applied after the clear, so a new
    // issue wins over a same-cycle retire to the same register.
    always_comb begin
        pending_d = pending_q;
        if (handshake && (lsu_addr != '0)) begin
            pending_d[lsu_addr] = 1'b0;
        end
        if (set_ok) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Output stage. Every output is held at zero while reset is asserted.
    // write_addr/write_data are zero whenever the port is idle.
    always_comb begin
        lsu_ready        = 1'b0;
        hazard_stall     = 1'b0;
        pipe_freeze      = 1'b0;
        regfile_write_en = 1'b0;
        write_addr       = '0;
        write_data       = '0;
        if (!rst) begin
            lsu_ready    = ready_c;
            hazard_stall = stall_c;
            pipe_freeze  = force_now;
            if (alu_win) begin
                regfile_write_en = 1'b1;
                write_addr       = alu_addr;
                write_data       = alu_data;
            end else if (handshake && (lsu_addr != '0)) begin
                regfile_write_en = 1'b1;
                write_addr       = lsu_addr;
                write_data       = lsu_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter. The reference model keeps the
// set of registers waiting for an LSU result as a plain bit array. It also
// counts the current run of cycles in which the LSU has been blocked. From
// these it derives the expected port owner, the handshake, the stall and the
// freeze for every cycle. The bench runs directed scenarios first, followed
// by a randomized run. Build with STARVE_GUARD_EN to exercise the guard.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int N        = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;
    localparam int NREG     = 2 ** ADDR_W;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              alu_we;
    logic [ADDR_W-1:0] alu_addr;
    logic [N-1:0]      alu_data;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_addr;
    logic [N-1:0]      lsu_data;
    logic              lsu_ready;
    logic              issue_lsu;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rs_ID;
    logic [ADDR_W-1:0] rt_ID;
    logic              hazard_stall;
    logic              pipe_freeze;
    logic              regfile_write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [N-1:0]      write_data;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit modelPend [NREG];
    int modelBlockedRun;
    bit modelLastReady;
    bit modelLastValid;

    regfile_wb_arbiter #(
        .N        (N),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_we           (alu_we),
        .alu_addr         (alu_addr),
        .alu_data         (alu_data),
        .lsu_valid        (lsu_valid),
        .lsu_addr         (lsu_addr),
        .lsu_data         (lsu_data),
        .lsu_ready        (lsu_ready),
        .issue_lsu        (issue_lsu),
        .issue_addr       (issue_addr),
        .rs_ID            (rs_ID),
        .rt_ID            (rt_ID),
        .hazard_stall     (hazard_stall),
        .pipe_freeze      (pipe_freeze),
        .regfile_write_en (regfile_write_en),
        .write_addr       (write_addr),
        .write_data       (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        rst        = 1'b0;
        alu_we     = 1'b0;
        alu_addr   = '0;
        alu_data   = '0;
        lsu_valid  = 1'b0;
        lsu_addr   = '0;
        lsu_data   = '0;
        issue_lsu  = 1'b0;
        issue_addr = '0;
        rs_ID      = '0;
        rt_ID      = '0;
    endtask

    // Inputs have been set just after a falling edge. Let them settle, then
    // compare every output with the model, and then advance the model state.
    task automatic applyStimulus(input string tag);
        bit fNow, aluWins, expReady, expWe, expStall;
        logic [ADDR_W-1:0] expAddr;
        logic [N-1:0]      expData;
        #1;
        if (rst) begin
            checkOutput({tag, ".rst_ready"}, 64'(lsu_ready), 64'd0);
            checkOutput({tag, ".rst_we"}, 64'(regfile_write_en), 64'd0);
            checkOutput({tag, ".rst_stall"}, 64'(hazard_stall), 64'd0);
            checkOutput({tag, ".rst_freeze"}, 64'(pipe_freeze), 64'd0);
            checkOutput({tag, ".rst_addr"}, 64'(write_addr), 64'd0);
            checkOutput({tag, ".rst_data"}, 64'(write_data), 64'd0);
            foreach (modelPend[i]) modelPend[i] = 1'b0;
            modelBlockedRun = 0;
            modelLastReady  = 1'b0;
            modelLastValid  = 1'b0;
            return;
        end
        fNow     = GUARD_ON && (modelBlockedRun == MAX_WAIT);
        aluWins  = alu_we && (alu_addr != 0) && !fNow;
        expReady = lsu_valid && !aluWins;
        expWe    = aluWins || (expReady && (lsu_addr != 0));
        expAddr  = aluWins ? alu_addr : lsu_addr;
        expData  = aluWins ? alu_data : lsu_data;
        expStall = fNow
                 || (modelPend[rs_ID] && !(expReady && lsu_addr == rs_ID))
                 || (modelPend[rt_ID] && !(expReady && lsu_addr == rt_ID))
                 || (issue_lsu && modelPend[issue_addr]);
        checkOutput({tag, ".ready"}, 64'(lsu_ready), 64'(expReady));
        checkOutput({tag, ".we"}, 64'(regfile_write_en), 64'(expWe));
        checkOutput({tag, ".stall"}, 64'(hazard_stall), 64'(expStall));
        checkOutput({tag, ".freeze"}, 64'(pipe_freeze), 64'(fNow));
        if (expWe) begin
            checkOutput({tag, ".addr"}, 64'(write_addr), 64'(expAddr));
            checkOutput({tag, ".data"}, 64'(write_data), 64'(expData));
        end
        if (expReady && lsu_addr != 0) modelPend[lsu_addr] = 1'b0;
        if (issue_lsu && !expStall && issue_addr != 0) modelPend[issue_addr] = 1'b1;
        if (fNow) modelBlockedRun = 0;
        else if (lsu_valid && !expReady) modelBlockedRun++;
        else modelBlockedRun = 0;
        modelLastReady = expReady;
        modelLastValid = lsu_valid;
    endtask

    initial begin
        clearInputs();
        foreach (modelPend[i]) modelPend[i] = 1'b0;
        modelBlockedRun = 0;
        modelLastReady  = 1'b0;
        modelLastValid  = 1'b0;

        // Reset for two cycles
        nextCycle();
        rst = 1'b1; alu_we = 1'b1; alu_addr = 5'd2; lsu_valid = 1'b1; lsu_addr = 5'd3;
        applyStimulus("reset0");
        nextCycle();
        applyStimulus("reset1");

        // ALU only
        nextCycle();
        clearInputs();
        alu_we = 1'b1; alu_addr = 5'd5; alu_data = 32'hA;
        applyStimulus("aluOnly");
        checkOutput("aluOnly.we_const", 64'(regfile_write_en), 64'd1);
        checkOutput("aluOnly.addr_const", 64'(write_addr), 64'd5);
        checkOutput("aluOnly.data_const", 64'(write_data), 64'hA);

        // Conflict, followed by the LSU retire
        nextCycle();
        alu_we = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h77;
        applyStimulus("conflict");
        checkOutput("conflict.addr_const", 64'(write_addr), 64'd3);
        checkOutput("conflict.ready_const", 64'(lsu_ready), 64'd0);
        nextCycle();
        alu_we = 1'b0;
        applyStimulus("conflictNext");
        checkOutput("conflictNext.addr_const", 64'(write_addr), 64'd7);
        checkOutput("conflictNext.ready_const", 64'(lsu_ready), 64'd1);

        // Starvation: the ALU is busy every cycle while the LSU holds its request
        nextCycle();
        clearInputs();
        lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_data = 32'hC0DE;
        for (int c = 1; c <= 6; c++) begin
            alu_we = 1'b1; alu_addr = 5'(c + 16); alu_data = 32'(c);
            applyStimulus("starve");
            if (GUARD_ON && c == 5) begin
                checkOutput("starve.force_freeze", 64'(pipe_freeze), 64'd1);
                checkOutput("starve.force_ready", 64'(lsu_ready), 64'd1);
                checkOutput("starve.force_addr", 64'(write_addr), 64'd12);
            end else if (GUARD_ON && c == 6) begin
                checkOutput("starve.after_addr", 64'(write_addr), 64'(c + 16));
                checkOutput("starve.after_freeze", 64'(pipe_freeze), 64'd0);
            end else begin
                checkOutput("starve.blocked_ready", 64'(lsu_ready), 64'd0);
            end
            nextCycle();
            if (GUARD_ON && c == 5) lsu_valid = 1'b0;
        end
        alu_we = 1'b0;
        applyStimulus("starveDrain");

        // Scoreboard on r9
        nextCycle();
        clearInputs();
        issue_lsu = 1'b1; issue_addr = 5'd9;
        applyStimulus("sbIssue");
        nextCycle();
        clearInputs();
        rs_ID = 5'd9;
        applyStimulus("sbStall");
        checkOutput("sbStall.const", 64'(hazard_stall), 64'd1);
        nextCycle();
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
        applyStimulus("sbRetire");
        checkOutput("sbRetire.stall_const", 64'(hazard_stall), 64'd0);
        checkOutput("sbRetire.ready_const", 64'(lsu_ready), 64'd1);
        nextCycle();
        lsu_valid = 1'b0;
        applyStimulus("sbCleared");
        checkOutput("sbCleared.const", 64'(hazard_stall), 64'd0);

        // r0 handling
        nextCycle();
        clearInputs();
        issue_lsu = 1'b1; issue_addr = 5'd0;
        applyStimulus("r0Issue");
        nextCycle();
        clearInputs();
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h1234;
        applyStimulus("r0Lsu");
        checkOutput("r0Lsu.ready_const", 64'(lsu_ready), 64'd1);
        checkOutput("r0Lsu.we_const", 64'(regfile_write_en), 64'd0);

        // Reset while the LSU is blocked and r4 is pending
        nextCycle();
        clearInputs();
        issue_lsu = 1'b1; issue_addr = 5'd4;
        applyStimulus("rstPrep");
        nextCycle();
        clearInputs();
        alu_we = 1'b1; alu_addr = 5'd1; lsu_valid = 1'b1; lsu_addr = 5'd4;
        applyStimulus("rstBlocked0");
        nextCycle();
        applyStimulus("rstBlocked1");
        nextCycle();
        rst = 1'b1; rs_ID = 5'd4;
        applyStimulus("rstMid");
        nextCycle();
        clearInputs();
        rs_ID = 5'd4;
        applyStimulus("rstAfter");
        checkOutput("rstAfter.stall_const", 64'(hazard_stall), 64'd0);
        checkOutput("rstAfter.freeze_const", 64'(pipe_freeze), 64'd0);

        // Randomized run. The LSU keeps its request stable until the handshake.
        for (int k = 0; k < 600; k++) begin
            nextCycle();
            rst      = ($urandom_range(0, 99) == 0);
            alu_we   = ($urandom_range(0, 99) < 55);
            alu_addr = 5'($urandom_range(0, 7));
            alu_data = $urandom;
            if (!(modelLastValid && !modelLastReady)) begin
                lsu_valid = ($urandom_range(0, 99) < 50);
                lsu_addr  = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            issue_lsu  = ($urandom_range(0, 99) < 30);
            issue_addr = 5'($urandom_range(0, 7));
            rs_ID      = 5'($urandom_range(0, 7));
            rt_ID      = 5'($urandom_range(0, 7));
            applyStimulus("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
